// File: rtl/wb_arbiter_if.sv
// Bundles the two producer handshakes and the register-file write-back port of wb_arbiter.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [REG_W-1:0]  reg_write;
  logic [DATA_W-1:0] data_write;
  logic              busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output reg_write, data_write, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  reg_write, data_write, busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs for ALU and MEM results feeding one change-sensitive write port.
// Define WB_PRIO_MEM_EN for fixed MEM priority instead of round-robin.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = REG_W + DATA_W;

  logic [ENT_W-1:0]  alu_fifo_q [DEPTH];
  logic [ENT_W-1:0]  mem_fifo_q [DEPTH];
  logic [PTR_W-1:0]  alu_wptr_q, alu_rptr_q, mem_wptr_q, mem_rptr_q;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;
  logic [REG_W-1:0]  reg_write_q, reg_write_d;
  logic [DATA_W-1:0] data_write_q, data_write_d;

  logic              alu_push, mem_push;
  logic              alu_ne, mem_ne;
  logic              alu_ok, mem_ok;
  logic              pref_alu;
  logic              gnt_alu, gnt_mem;
  logic [ENT_W-1:0]  alu_head, mem_head, cur_pair;

  assign bus.alu_ready = (alu_cnt_q < CNT_W'(DEPTH)) && !rst;
  assign bus.mem_ready = (mem_cnt_q < CNT_W'(DEPTH)) && !rst;

  // rd == 0 completes the handshake but never enters the FIFO
  assign alu_push = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
  assign mem_push = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);

  assign alu_ne   = (alu_cnt_q != '0);
  assign mem_ne   = (mem_cnt_q != '0);
  assign alu_head = alu_fifo_q[alu_rptr_q];
  assign mem_head = mem_fifo_q[mem_rptr_q];
  assign cur_pair = {reg_write_q, data_write_q};

  // A head matching the pair already on the port would be invisible to the change-sensitive writer
  assign alu_ok = alu_ne && !((reg_write_q != '0) && (alu_head == cur_pair));
  assign mem_ok = mem_ne && !((reg_write_q != '0) && (mem_head == cur_pair));

`ifdef WB_PRIO_MEM_EN
  assign pref_alu = !mem_ne;
`else
  localparam logic [0:0] LAST_ALU = 1'b0;
  localparam logic [0:0] LAST_MEM = 1'b1;

  logic [0:0] last_q;

  assign pref_alu = alu_ne && (!mem_ne || (last_q == LAST_MEM));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_MEM;
    end else if (gnt_alu) begin
      last_q <= LAST_ALU;
    end else if (gnt_mem) begin
      last_q <= LAST_MEM;
    end
  end
`endif

  // Preferred source yields to the other one only when its own head is a duplicate
  assign gnt_alu = pref_alu ? alu_ok : (alu_ok && !mem_ok);
  assign gnt_mem = pref_alu ? (mem_ok && !alu_ok) : mem_ok;

  always_comb begin
    alu_cnt_d    = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(gnt_alu);
    mem_cnt_d    = mem_cnt_q + CNT_W'(mem_push) - CNT_W'(gnt_mem);
    reg_write_d  = '0;
    data_write_d = data_write_q;
    if (gnt_alu) begin
      {reg_write_d, data_write_d} = alu_head;
    end else if (gnt_mem) begin
      {reg_write_d, data_write_d} = mem_head;
    end
  end

  // Stage boundary: FIFO storage (data only, never reset)
  always_ff @(posedge clk) begin
    if (alu_push) alu_fifo_q[alu_wptr_q] <= {bus.alu_rd, bus.alu_data};
    if (mem_push) mem_fifo_q[mem_wptr_q] <= {bus.mem_rd, bus.mem_data};
  end

  // Stage boundary: FIFO control and write-back port
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wptr_q   <= '0;
      alu_rptr_q   <= '0;
      alu_cnt_q    <= '0;
      mem_wptr_q   <= '0;
      mem_rptr_q   <= '0;
      mem_cnt_q    <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
    end else begin
      if (alu_push) alu_wptr_q <= alu_wptr_q + PTR_W'(1);
      if (gnt_alu)  alu_rptr_q <= alu_rptr_q + PTR_W'(1);
      if (mem_push) mem_wptr_q <= mem_wptr_q + PTR_W'(1);
      if (gnt_mem)  mem_rptr_q <= mem_rptr_q + PTR_W'(1);
      alu_cnt_q    <= alu_cnt_d;
      mem_cnt_q    <= mem_cnt_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
    end
  end

  assign bus.reg_write  = reg_write_q;
  assign bus.data_write = data_write_q;
  assign bus.busy       = alu_ne || mem_ne || (reg_write_q != '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a queue-based write-back model.
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 4;
  localparam int OW     = REG_W + DATA_W + 3;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus();

  wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  ent_t              aq[$];
  ent_t              mq[$];
  bit                m_last_mem = 1'b1;
  logic [REG_W-1:0]  m_rw = '0;
  logic [DATA_W-1:0] m_dw = '0;

  function automatic bit is_dup(ent_t e);
    return (m_rw != 0) && (e.rd == m_rw) && (e.data == m_dw);
  endfunction

  // One clock edge of the reference: pick by rule, then append accepted pushes
  task automatic model_step();
    ent_t win;
    bit a_ok, m_ok, alu_first, g_a, g_m, a_rdy, m_rdy;
    if (rst) begin
      aq.delete(); mq.delete();
      m_rw = '0; m_dw = '0; m_last_mem = 1'b1;
      return;
    end
    a_rdy = aq.size() < DEPTH;
    m_rdy = mq.size() < DEPTH;
    a_ok  = (aq.size() > 0) && !is_dup(aq[0]);
    m_ok  = (mq.size() > 0) && !is_dup(mq[0]);
`ifdef WB_PRIO_MEM_EN
    alu_first = 1'b0;
`else
    alu_first = m_last_mem;
`endif
    g_a = a_ok && (alu_first || !m_ok);
    g_m = m_ok && !g_a;
    win = '0;
    if (g_a) begin win = aq.pop_front(); m_last_mem = 1'b0; end
    else if (g_m) begin win = mq.pop_front(); m_last_mem = 1'b1; end
    if (g_a || g_m) begin m_rw = win.rd; m_dw = win.data; end
    else m_rw = '0;
    if (bus.alu_valid && a_rdy && bus.alu_rd != 0) aq.push_back(ent_t'({bus.alu_rd, bus.alu_data}));
    if (bus.mem_valid && m_rdy && bus.mem_rd != 0) mq.push_back(ent_t'({bus.mem_rd, bus.mem_data}));
  endtask

  function automatic logic [OW-1:0] model_out();
    return {m_rw, m_dw, (aq.size() != 0 || mq.size() != 0 || m_rw != 0),
            (!rst && aq.size() < DEPTH), (!rst && mq.size() < DEPTH)};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.reg_write, bus.data_write, bus.busy, bus.alu_ready, bus.mem_ready};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
  endtask

  task automatic drive_alu(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic drive_mem(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    bus.mem_valid = 1'b1; bus.mem_rd = rd; bus.mem_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    n_cmp++;
    if (dut_out() !== model_out())
      $display("FAIL reset_model: got %h want %h", dut_out(), model_out());
    n_cmp++;
    if (dut_out() !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", dut_out());
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b want 11", {bus.alu_ready, bus.mem_ready});
    end
  endtask

  task automatic test_single();
    logic [REG_W-1:0] rw_seq [3];
    logic             busy_seq [3];
    drive_alu(5, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      set_idle();
      rw_seq[i]   = bus.reg_write;
      busy_seq[i] = bus.busy;
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL single_model[%0d]: got %h want %h", i, dut_out(), model_out());
      end
      if (i == 1) begin
        n_cmp++;
        if ({bus.reg_write, bus.data_write} !== {5'd5, 32'h10}) begin
          n_err++;
          $display("FAIL single_write: got %0d/%h want 5/10", bus.reg_write, bus.data_write);
        end
      end
    end
    n_cmp++;
    if (rw_seq[2] !== '0 || busy_seq[2] !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got rw=%0d busy=%b want rw=0 busy=0", rw_seq[2], busy_seq[2]);
    end
  endtask

  task automatic test_simultaneous();
    logic [REG_W-1:0] first_rd, second_rd;
    rst = 1'b1; set_idle(); tick(); rst = 1'b0;
    drive_alu(3, 32'hA);
    drive_mem(4, 32'hB);
    tick();
    set_idle();
    tick();
    first_rd = bus.reg_write;
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL simul_model0: got %h want %h", dut_out(), model_out());
    end
    tick();
    second_rd = bus.reg_write;
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL simul_model1: got %h want %h", dut_out(), model_out());
    end
    n_cmp++;
`ifdef WB_PRIO_MEM_EN
    if ({first_rd, second_rd} !== {5'd4, 5'd3}) begin
      n_err++;
      $display("FAIL simul_order: got %0d,%0d want 4,3", first_rd, second_rd);
    end
`else
    if ({first_rd, second_rd} !== {5'd3, 5'd4}) begin
      n_err++;
      $display("FAIL simul_order: got %0d,%0d want 3,4", first_rd, second_rd);
    end
`endif
    tick();
  endtask

  task automatic test_duplicate();
    logic [REG_W-1:0] seq [4];
    drive_alu(7, 32'h55);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      set_idle();
      seq[i] = bus.reg_write;
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL dup_model[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
    n_cmp++;
    if ({seq[0], seq[1], seq[2], seq[3]} !== {5'd7, 5'd0, 5'd7, 5'd0}) begin
      n_err++;
      $display("FAIL dup_seq: got %0d,%0d,%0d,%0d want 7,0,7,0", seq[0], seq[1], seq[2], seq[3]);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    bit saw_stall = 1'b0;
    rst = 1'b1; set_idle(); tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 60 && accepted < 10; cyc++) begin
      drive_alu(REG_W'(9), 32'h100 + accepted);
      drive_mem(REG_W'(20), 32'h200 + cyc);
      if (bus.alu_ready) accepted++;
      else saw_stall = 1'b1;
      tick();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL bp_model[%0d]: got %h want %h", cyc, dut_out(), model_out());
      end
    end
    set_idle();
    for (int i = 0; i < 24; i++) begin
      tick();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL bp_drain[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
    n_cmp++;
    if (accepted != 10 || !saw_stall || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_summary: got acc=%0d stall=%b busy=%b want 10/1/0", accepted, saw_stall, bus.busy);
    end
  endtask

  task automatic test_discard();
    set_idle();
    tick();
    drive_alu(0, 32'hFF);
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL discard_ready: got %b want 1", bus.alu_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      set_idle();
      n_cmp++;
      if (bus.reg_write !== '0 || bus.busy !== 1'b0 || dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL discard[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      bus.alu_valid = ($urandom_range(0, 2) != 0);
      bus.alu_rd    = REG_W'($urandom_range(0, 3));
      bus.alu_data  = DATA_W'($urandom_range(0, 2));
      bus.mem_valid = ($urandom_range(0, 2) != 0);
      bus.mem_rd    = REG_W'($urandom_range(0, 3));
      bus.mem_data  = DATA_W'($urandom_range(0, 2));
      tick();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
    rst = 1'b0;
    set_idle();
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive_alu(REG_W'(10 + i), 32'h300 + i);
      drive_mem(REG_W'(16 + i), 32'h400 + i);
      tick();
    end
    set_idle();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.reg_write !== '0 || bus.busy !== 1'b0 || dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL reset_mid: got %h want %h", dut_out(), model_out());
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (bus.reg_write !== '0 || bus.busy !== 1'b0 || dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL reset_mid_stale[%0d]: got %h want %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_single();
    test_simultaneous();
    test_duplicate();
    test_backpressure();
    test_discard();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
